// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the single-PE convolution sequencer:
//   - state_t : sequencer state encoding (IDLE / LOAD / MAC / DONE)
//   - geometry constants for a 4x4 input, a 3x3 filter and a 2x2 output
//   - tap-to-(kr,kc) lookup tables; tap k walks the filter in row-major order
// ---------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int N_TAPS = 9;
    localparam int N_OUT  = 4;
    localparam int IN_DIM = 4;
    localparam int K_DIM  = 3;

    localparam logic [3:0] LAST_TAP = 4'(N_TAPS - 1);
    localparam logic [1:0] LAST_OUT = 2'(N_OUT - 1);

    // kr = tap / 3, kc = tap % 3
    localparam logic [1:0] TAP_KR [N_TAPS] = '{2'd0, 2'd0, 2'd0,
                                               2'd1, 2'd1, 2'd1,
                                               2'd2, 2'd2, 2'd2};
    localparam logic [1:0] TAP_KC [N_TAPS] = '{2'd0, 2'd1, 2'd2,
                                               2'd0, 2'd1, 2'd2,
                                               2'd0, 2'd1, 2'd2};

endpackage

// File: rtl/conv_pe_seq_if.sv
// ---------------------------------------------------------------------------
// conv_pe_seq_if
// Bus between the operand/result memory (master) and the convolution
// sequencer (slave).
//   start_i            : start request (memory done_capture), edge-detected
//   a11..a44           : 4x4 input matrix, row-major
//   b11..b33           : 3x3 filter, row-major
//   c11, c12, c21, c22 : 2x2 convolution results
//   valid_o            : one-cycle result pulse (memory PE_valid_i)
//   busy_o             : high while a computation is in progress
// ---------------------------------------------------------------------------
interface conv_pe_seq_if #(
    parameter int DATA_W = 8
);
    logic              start_i;
    logic [DATA_W-1:0] a11, a12, a13, a14;
    logic [DATA_W-1:0] a21, a22, a23, a24;
    logic [DATA_W-1:0] a31, a32, a33, a34;
    logic [DATA_W-1:0] a41, a42, a43, a44;
    logic [DATA_W-1:0] b11, b12, b13;
    logic [DATA_W-1:0] b21, b22, b23;
    logic [DATA_W-1:0] b31, b32, b33;
    logic [DATA_W-1:0] c11, c12, c21, c22;
    logic              valid_o;
    logic              busy_o;

    modport master (
        output start_i,
        output a11, a12, a13, a14, a21, a22, a23, a24,
        output a31, a32, a33, a34, a41, a42, a43, a44,
        output b11, b12, b13, b21, b22, b23, b31, b32, b33,
        input  c11, c12, c21, c22,
        input  valid_o, busy_o
    );

    modport slave (
        input  start_i,
        input  a11, a12, a13, a14, a21, a22, a23, a24,
        input  a31, a32, a33, a34, a41, a42, a43, a44,
        input  b11, b12, b13, b21, b22, b23, b31, b32, b33,
        output c11, c12, c21, c22,
        output valid_o, busy_o
    );
endinterface

// File: rtl/conv_mac.sv
// ---------------------------------------------------------------------------
// conv_mac
// Unsigned multiply-accumulate unit for the convolution sequencer.
//   clk, reset : clock, asynchronous active-high reset
//   clear_i    : zero the accumulator
//   add_i      : accumulate a_i * b_i
//   store_i    : with add_i, this is the last tap: acc restarts at zero
//   a_i, b_i   : operands (DATA_W, unsigned)
//   result_o   : acc + a_i*b_i converted to DATA_W (value to store on the
//                last tap)
// Build option: SATURATE_EN defined -> result clamps to 2^DATA_W-1;
// otherwise the low DATA_W bits are kept.
// ---------------------------------------------------------------------------
module conv_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              add_i,
    input  logic              store_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    sum;
    logic [ACC_W-1:0]    acc_q, acc_d;

    function automatic logic [DATA_W-1:0] to_result(input logic [ACC_W-1:0] v);
`ifdef SATURATE_EN
        if (|v[ACC_W-1:DATA_W]) begin
            return '1;
        end
        return v[DATA_W-1:0];
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    assign prod     = a_i * b_i;
    assign sum      = acc_q + ACC_W'(prod);
    assign result_o = to_result(sum);

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (add_i) begin
            // the stored sum leaves the accumulator; next output starts at 0
            acc_d = store_i ? '0 : sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/conv_pe_seq.sv
// ---------------------------------------------------------------------------
// conv_pe_seq
// Single-PE convolution sequencer: snapshots a 4x4 input and a 3x3 filter,
// computes the 2x2 valid convolution with one MAC per cycle (36 cycles),
// then presents c11..c22 together with a one-cycle valid_o pulse.
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : conv_pe_seq_if.slave (start_i, a11..a44, b11..b33,
//           c11..c22, valid_o, busy_o)
// Timing: start edge at E0 -> LOAD -> 36 x MAC -> DONE; valid_o is high
// in the cycle after E37. start_i edges outside IDLE are dropped.
// Build option: SATURATE_EN (see conv_mac) selects saturating results.
// ---------------------------------------------------------------------------
module conv_pe_seq
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic         clk,
    input  logic         reset,
    conv_pe_seq_if.slave bus
);

    localparam int N_A = IN_DIM * IN_DIM;
    localparam int N_B = K_DIM * K_DIM;

    state_t            state_q, state_d;
    logic              start_q, start_d;
    logic [3:0]        tap_q, tap_d;
    logic [1:0]        out_idx_q, out_idx_d;
    logic [DATA_W-1:0] a_snap_q [N_A];
    logic [DATA_W-1:0] a_snap_d [N_A];
    logic [DATA_W-1:0] b_snap_q [N_B];
    logic [DATA_W-1:0] b_snap_d [N_B];
    logic [DATA_W-1:0] res_q [N_OUT];
    logic [DATA_W-1:0] res_d [N_OUT];
    logic [DATA_W-1:0] c_q [N_OUT];
    logic [DATA_W-1:0] c_d [N_OUT];

    logic [DATA_W-1:0] a_in [N_A];
    logic [DATA_W-1:0] b_in [N_B];

    logic              mac_clear, mac_add, mac_store;
    logic [DATA_W-1:0] mac_a, mac_b, mac_result;
    logic [1:0]        row, col;

    assign a_in[0]  = bus.a11;  assign a_in[1]  = bus.a12;
    assign a_in[2]  = bus.a13;  assign a_in[3]  = bus.a14;
    assign a_in[4]  = bus.a21;  assign a_in[5]  = bus.a22;
    assign a_in[6]  = bus.a23;  assign a_in[7]  = bus.a24;
    assign a_in[8]  = bus.a31;  assign a_in[9]  = bus.a32;
    assign a_in[10] = bus.a33;  assign a_in[11] = bus.a34;
    assign a_in[12] = bus.a41;  assign a_in[13] = bus.a42;
    assign a_in[14] = bus.a43;  assign a_in[15] = bus.a44;

    assign b_in[0] = bus.b11;  assign b_in[1] = bus.b12;  assign b_in[2] = bus.b13;
    assign b_in[3] = bus.b21;  assign b_in[4] = bus.b22;  assign b_in[5] = bus.b23;
    assign b_in[6] = bus.b31;  assign b_in[7] = bus.b32;  assign b_in[8] = bus.b33;

    // Operand mux: output (r,c) = out_idx bits, filter tap (kr,kc);
    // input element index is row*4 + col, i.e. {row, col}.
    always_comb begin
        row   = {1'b0, out_idx_q[1]} + TAP_KR[tap_q];
        col   = {1'b0, out_idx_q[0]} + TAP_KC[tap_q];
        mac_a = a_snap_q[{row, col}];
        mac_b = b_snap_q[tap_q];
    end

    always_comb begin
        state_d   = state_q;
        start_d   = bus.start_i;
        tap_d     = tap_q;
        out_idx_d = out_idx_q;
        a_snap_d  = a_snap_q;
        b_snap_d  = b_snap_q;
        res_d     = res_q;
        c_d       = c_q;
        mac_clear = 1'b0;
        mac_add   = 1'b0;
        mac_store = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i && !start_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                a_snap_d  = a_in;
                b_snap_d  = b_in;
                tap_d     = '0;
                out_idx_d = '0;
                mac_clear = 1'b1;
                state_d   = MAC;
            end
            MAC: begin
                mac_add = 1'b1;
                if (tap_q == LAST_TAP) begin
                    mac_store          = 1'b1;
                    res_d[out_idx_q]   = mac_result;
                    tap_d              = '0;
                    out_idx_d          = out_idx_q + 2'd1;
                    if (out_idx_q == LAST_OUT) begin
                        // res_d already carries the final result, so all
                        // four outputs change on the same edge
                        c_d     = res_d;
                        state_d = DONE;
                    end
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            tap_q     <= '0;
            out_idx_q <= '0;
            for (int i = 0; i < N_A; i++) a_snap_q[i] <= '0;
            for (int i = 0; i < N_B; i++) b_snap_q[i] <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                res_q[i] <= '0;
                c_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            tap_q     <= tap_d;
            out_idx_q <= out_idx_d;
            a_snap_q  <= a_snap_d;
            b_snap_q  <= b_snap_d;
            res_q     <= res_d;
            c_q       <= c_d;
        end
    end

    conv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (mac_clear),
        .add_i    (mac_add),
        .store_i  (mac_store),
        .a_i      (mac_a),
        .b_i      (mac_b),
        .result_o (mac_result)
    );

    assign bus.c11     = c_q[0];
    assign bus.c12     = c_q[1];
    assign bus.c21     = c_q[2];
    assign bus.c22     = c_q[3];
    assign bus.valid_o = (state_q == DONE);
    assign bus.busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_conv_pe_seq.sv
// ---------------------------------------------------------------------------
// tb_conv_pe_seq
// Directed bench for conv_pe_seq: a table of operand sets with hand-computed
// 2x2 results, plus sequences for held start, mid-run input changes, and
// reset during a run / with start held high.
// ---------------------------------------------------------------------------
module tb_conv_pe_seq;

    localparam int DW = 8;

`ifdef SATURATE_EN
    localparam int FULL_EXP = 255;   // 585225 clamps
    localparam int MID_EXP  = 255;   // 288 clamps
`else
    localparam int FULL_EXP = 9;     // 585225 mod 256
    localparam int MID_EXP  = 32;    // 288 mod 256
`endif

    typedef struct packed {
        logic [15:0][7:0] a;
        logic [8:0][7:0]  b;
        logic [3:0][31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_pe_seq_if #(.DATA_W(DW)) bus ();

    conv_pe_seq #(.DATA_W(DW), .ACC_W(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    integer checks = 0;
    integer errors = 0;
    integer cyc, first_valid, valid_cnt, busy_cnt;
    integer c_cap [4];
    vec_t   vecs [6];

    logic [15:0][7:0] a_seq, a_ones, a_ff, a_sp, a_16;
    logic [8:0][7:0]  b_id, b_ones, b_ff, b_ramp, b_2;

    task automatic check(input string name, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic integer c_now(input int j);
        case (j)
            0:       return integer'(bus.c11);
            1:       return integer'(bus.c12);
            2:       return integer'(bus.c21);
            default: return integer'(bus.c22);
        endcase
    endfunction

    task automatic apply_ops(input logic [15:0][7:0] a, input logic [8:0][7:0] b);
        bus.a11 = a[0];  bus.a12 = a[1];  bus.a13 = a[2];  bus.a14 = a[3];
        bus.a21 = a[4];  bus.a22 = a[5];  bus.a23 = a[6];  bus.a24 = a[7];
        bus.a31 = a[8];  bus.a32 = a[9];  bus.a33 = a[10]; bus.a34 = a[11];
        bus.a41 = a[12]; bus.a42 = a[13]; bus.a43 = a[14]; bus.a44 = a[15];
        bus.b11 = b[0];  bus.b12 = b[1];  bus.b13 = b[2];
        bus.b21 = b[3];  bus.b22 = b[4];  bus.b23 = b[5];
        bus.b31 = b[6];  bus.b32 = b[7];  bus.b33 = b[8];
    endtask

    task automatic clear_mon();
        cyc = 0; first_valid = 0; valid_cnt = 0; busy_cnt = 0;
        for (int j = 0; j < 4; j++) c_cap[j] = -1;
    endtask

    // advance n cycles, sampling on the falling edge
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.busy_o === 1'b1) busy_cnt++;
            if (bus.valid_o === 1'b1) begin
                valid_cnt++;
                if (first_valid == 0) first_valid = cyc;
                for (int j = 0; j < 4; j++) c_cap[j] = c_now(j);
            end
        end
    endtask

    task automatic check_results(input string tag, input vec_t v);
        for (int j = 0; j < 4; j++)
            check($sformatf("%s c[%0d]", tag, j), c_cap[j], integer'(v.exp[j]));
    endtask

    task automatic do_run(input vec_t v, input string tag);
        apply_ops(v.a, v.b);
        clear_mon();
        bus.start_i = 1'b1;
        run_cycles(45);
        bus.start_i = 1'b0;
        check({tag, " latency"}, first_valid, 38);
        check({tag, " valid pulses"}, valid_cnt, 1);
        check({tag, " busy cycles"}, busy_cnt, 38);
        check_results(tag, v);
        for (int j = 0; j < 4; j++)
            check($sformatf("%s hold c[%0d]", tag, j), c_now(j), integer'(v.exp[j]));
        run_cycles(2);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            a_seq[i]  = 8'(i + 1);
            a_ones[i] = 8'd1;
            a_ff[i]   = 8'd255;
            a_sp[i]   = 8'd0;
            a_16[i]   = 8'd16;
        end
        a_sp[0]  = 8'd2;
        a_sp[15] = 8'd3;
        for (int i = 0; i < 9; i++) begin
            b_id[i]   = 8'd0;
            b_ones[i] = 8'd1;
            b_ff[i]   = 8'd255;
            b_ramp[i] = 8'(i + 1);
            b_2[i]    = 8'd2;
        end
        b_id[4] = 8'd1;

        vecs[0] = '{a: a_seq,  b: b_id,   exp: '{32'd11, 32'd10, 32'd7, 32'd6}};
        vecs[1] = '{a: a_ones, b: b_ones, exp: '{32'd9, 32'd9, 32'd9, 32'd9}};
        vecs[2] = '{a: a_ff,   b: b_ff,   exp: '{FULL_EXP, FULL_EXP, FULL_EXP, FULL_EXP}};
        vecs[3] = '{a: a_seq,  b: b_ones, exp: '{32'd99, 32'd90, 32'd63, 32'd54}};
        vecs[4] = '{a: a_sp,   b: b_ramp, exp: '{32'd27, 32'd0, 32'd0, 32'd2}};
        vecs[5] = '{a: a_16,   b: b_2,    exp: '{MID_EXP, MID_EXP, MID_EXP, MID_EXP}};

        // reset state
        reset = 1'b1;
        bus.start_i = 1'b0;
        apply_ops('0, '0);
        clear_mon();
        repeat (2) @(negedge clk);
        check("reset valid_o", integer'(bus.valid_o), 0);
        check("reset busy_o", integer'(bus.busy_o), 0);
        for (int j = 0; j < 4; j++) check($sformatf("reset c[%0d]", j), c_now(j), 0);
        reset = 1'b0;
        run_cycles(2);
        check("idle no busy", busy_cnt, 0);

        // table
        for (int k = 0; k < 6; k++) do_run(vecs[k], $sformatf("vec%0d", k));

        // a inputs zeroed after the snapshot has been taken
        apply_ops(vecs[0].a, vecs[0].b);
        clear_mon();
        bus.start_i = 1'b1;
        run_cycles(2);
        apply_ops('0, vecs[0].b);
        run_cycles(43);
        bus.start_i = 1'b0;
        check("late-change valid pulses", valid_cnt, 1);
        check_results("late-change", vecs[0]);
        run_cycles(2);

        // start held high 100 cycles with an extra edge mid-run
        apply_ops(vecs[0].a, vecs[0].b);
        clear_mon();
        bus.start_i = 1'b1;
        run_cycles(10);
        bus.start_i = 1'b0;
        run_cycles(1);
        bus.start_i = 1'b1;
        run_cycles(89);
        check("held valid pulses", valid_cnt, 1);
        check("held latency", first_valid, 38);
        check("held busy cycles", busy_cnt, 38);
        check_results("held", vecs[0]);
        bus.start_i = 1'b0;
        run_cycles(2);
        apply_ops(vecs[3].a, vecs[3].b);
        clear_mon();
        bus.start_i = 1'b1;
        run_cycles(45);
        bus.start_i = 1'b0;
        check("restart valid pulses", valid_cnt, 1);
        check_results("restart", vecs[3]);
        run_cycles(2);

        // reset in the middle of a run
        apply_ops(vecs[0].a, vecs[0].b);
        clear_mon();
        bus.start_i = 1'b1;
        run_cycles(20);
        reset = 1'b1;
        bus.start_i = 1'b0;
        #1;
        check("abort valid_o", integer'(bus.valid_o), 0);
        check("abort busy_o", integer'(bus.busy_o), 0);
        for (int j = 0; j < 4; j++) check($sformatf("abort c[%0d]", j), c_now(j), 0);
        clear_mon();
        run_cycles(3);
        reset = 1'b0;
        run_cycles(45);
        check("abort no valid", valid_cnt, 0);
        check("abort stays idle", busy_cnt, 0);
        do_run(vecs[1], "after-abort");

        // start high across reset counts as an edge once reset releases
        apply_ops(vecs[3].a, vecs[3].b);
        reset = 1'b1;
        bus.start_i = 1'b1;
        run_cycles(2);
        clear_mon();
        reset = 1'b0;
        run_cycles(45);
        bus.start_i = 1'b0;
        check("start-over-reset valid pulses", valid_cnt, 1);
        check("start-over-reset latency", first_valid, 38);
        check_results("start-over-reset", vecs[3]);
        run_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
